// File: rtl/cp0_int_unit_pkg.sv
// Shared CP0 definitions: commit opcodes and register numbers used by control,
// plus the local commit-action enum and the handler-vector helper.
package cp0_int_unit_pkg;

  // Committed CP0 command encoding, shared with the control unit.
  localparam int unsigned CP0_OP_BIT = 2;
  localparam logic [CP0_OP_BIT-1:0] CP0_OP_NOP = 2'd0;
  localparam logic [CP0_OP_BIT-1:0] CP0_OP_IRQ = 2'd1;
  localparam logic [CP0_OP_BIT-1:0] CP0_OP_RET = 2'd2;

  // CP0 register numbers as decoded from rd by control.
  localparam logic [4:0] CP0_REG_EPC = 5'd0;
  localparam logic [4:0] CP0_REG_IE  = 5'd1;

  // The single action taken at commit in a given cycle.
  typedef enum logic [1:0] {
    ActNone,
    ActIrq,
    ActRet,
    ActMtc0
  } cp0_act_e;

  // Handler address for a line index; wraps at 32 bits.
  function automatic logic [31:0] cp0_vec_addr(input logic [31:0] base,
                                               input logic [31:0] stride,
                                               input logic [31:0] idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/cp0_irq_prio_enc.sv
// Fixed-priority encoder: lowest set index of the eligible mask wins.
module cp0_irq_prio_enc #(
  parameter int unsigned NUM_IRQ = 3,
  localparam int unsigned SEL_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] eligible_i,
  output logic [SEL_W-1:0]   sel_o,
  output logic               valid_o
);

  // Scan from the top down so the lowest eligible index is the last to win.
  always_comb begin
    sel_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        sel_o   = SEL_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_int_unit.sv
// CP0 interrupt responder: captures interrupt edges, raises the interrupt request
// to control, and executes committed IRQ entry / ERET / MTC0 to IE and EPC.
// Optional macro CP0_NESTED_EN: EPC stack with level-based preemption instead of a
// single EPC and an in-service flag.
// The interrupt-request output is named int_req because `int` is a reserved word.
module cp0_int_unit
  import cp0_int_unit_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
  parameter int unsigned EPC_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_IRQ-1:0]    irq_in,
  input  logic [CP0_OP_BIT-1:0] op_cp0,
  input  logic                  w_en_ie,
  input  logic                  w_en_epc,
  input  logic [31:0]           cp0_w_data,
  input  logic [31:0]           pc_in,
  output logic                  int_req,
  output logic [31:0]           int_vector,
  output logic [31:0]           ie,
  output logic [31:0]           epc,
  output logic [NUM_IRQ-1:0]    pending
);

  localparam int unsigned SEL_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0] pending_q, pending_d, irq_prev_q, rise, eligible;
  logic [31:0]        ie_q, ie_d;
  logic [SEL_W-1:0]   sel;
  logic               any_elig;
  cp0_act_e           act;

  cp0_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .eligible_i (eligible),
    .sel_o      (sel),
    .valid_o    (any_elig)
  );

  assign rise       = irq_in & ~irq_prev_q;
  assign int_req    = any_elig;
  assign int_vector = cp0_vec_addr(VEC_BASE, VEC_STRIDE, 32'(sel));
  assign ie         = ie_q;
  assign pending    = pending_q;

  // Commit decode; an IRQ commit with no eligible interrupt is a stale entry.
  always_comb begin
    act = ActNone;
    if (op_cp0 == CP0_OP_IRQ) begin
      act = (w_en_epc && int_req) ? ActIrq : ActNone;
    end else if (op_cp0 == CP0_OP_RET) begin
      act = ActRet;
    end else if (op_cp0 == CP0_OP_NOP) begin
      act = ActMtc0;
    end
  end

  // Pending and IE next state; a new rising edge beats the entry clear.
  always_comb begin
    pending_d = pending_q;
    ie_d      = ie_q;
    if (act == ActIrq) begin
      pending_d[sel] = 1'b0;
`ifndef CP0_NESTED_EN
      ie_d[0] = 1'b0;
`endif
    end
    if (act == ActRet) begin
      ie_d[0] = 1'b1;
    end
    if (act == ActMtc0 && w_en_ie) begin
      ie_d = cp0_w_data;
    end
    pending_d = pending_d | rise;
  end

  // Edge-capture, pending and IE registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      ie_q       <= '0;
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      ie_q       <= ie_d;
    end
  end

`ifdef CP0_NESTED_EN
  localparam int unsigned SP_W  = $clog2(EPC_DEPTH + 1);
  localparam int unsigned IDX_W = (EPC_DEPTH > 1) ? $clog2(EPC_DEPTH) : 1;

  logic [31:0]      stk_epc_q [EPC_DEPTH];
  logic [SEL_W-1:0] stk_lvl_q [EPC_DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic [IDX_W-1:0] top_idx, push_idx;
  logic             stk_full;
  logic [NUM_IRQ-1:0] lvl_mask;

  // With an empty stack the top index reads slot 0, which holds the last EPC.
  assign top_idx  = (sp_q == '0) ? '0 : IDX_W'(sp_q - 1'b1);
  assign push_idx = IDX_W'(sp_q);
  assign stk_full = (sp_q == SP_W'(EPC_DEPTH));
  assign epc      = stk_epc_q[top_idx];

  // Only lines strictly above the in-service level may preempt; full stack blocks all.
  always_comb begin
    lvl_mask = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      lvl_mask[i] = (sp_q == '0) || (SEL_W'(i) < stk_lvl_q[top_idx]);
    end
    eligible = stk_full ? '0 : (pending_q & lvl_mask);
  end

  // EPC/level stack: push on entry, pop on ERET, MTC0 rewrites the top EPC.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
      for (int i = 0; i < EPC_DEPTH; i++) begin
        stk_epc_q[i] <= '0;
        stk_lvl_q[i] <= '0;
      end
    end else begin
      unique case (act)
        ActIrq: begin
          stk_epc_q[push_idx] <= pc_in;
          stk_lvl_q[push_idx] <= sel;
          sp_q                <= sp_q + 1'b1;
        end
        ActRet: begin
          if (sp_q != '0) sp_q <= sp_q - 1'b1;
        end
        ActMtc0: begin
          if (w_en_epc) stk_epc_q[top_idx] <= cp0_w_data;
        end
        default: ;
      endcase
    end
  end
`else
  logic [31:0] epc_q;
  logic        in_service_q;

  assign epc      = epc_q;
  assign eligible = in_service_q ? '0 : pending_q;

  // Single EPC and in-service flag; nothing preempts a running handler.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q        <= '0;
      in_service_q <= 1'b0;
    end else begin
      unique case (act)
        ActIrq: begin
          epc_q        <= pc_in;
          in_service_q <= 1'b1;
        end
        ActRet: in_service_q <= 1'b0;
        ActMtc0: begin
          if (w_en_epc) epc_q <= cp0_w_data;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_cp0_int_unit.sv
// Scoreboard bench for cp0_int_unit: the stimulus process queues hand-computed
// expectations per cycle, the monitor pops and compares on the falling edge.
// Expectations follow CP0_NESTED_EN when it is defined.
module tb_cp0_int_unit;
  import cp0_int_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  irq_in = '0;
  logic [1:0]  op_cp0 = CP0_OP_NOP;
  logic        w_en_ie = 1'b0;
  logic        w_en_epc = 1'b0;
  logic [31:0] cp0_w_data = '0;
  logic [31:0] pc_in = '0;
  logic        int_req;
  logic [31:0] int_vector, ie, epc;
  logic [2:0]  pending;

  cp0_int_unit #(
    .NUM_IRQ    (3),
    .VEC_BASE   (32'h0000_0800),
    .VEC_STRIDE (32'h0000_0010),
    .EPC_DEPTH  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .op_cp0     (op_cp0),
    .w_en_ie    (w_en_ie),
    .w_en_epc   (w_en_epc),
    .cp0_w_data (cp0_w_data),
    .pc_in      (pc_in),
    .int_req    (int_req),
    .int_vector (int_vector),
    .ie         (ie),
    .epc        (epc),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic        i;
    logic [31:0] vec;
    logic [31:0] ie;
    logic [31:0] epc;
    logic [2:0]  pend;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (int_req !== e.i || int_vector !== e.vec || ie !== e.ie || epc !== e.epc ||
          pending !== e.pend || e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: got int=%b vec=%h ie=%h epc=%h pend=%b, want int=%b vec=%h ie=%h epc=%h pend=%b (cyc %0d/%0d)",
                 e.name, int_req, int_vector, ie, epc, pending,
                 e.i, e.vec, e.ie, e.epc, e.pend, cyc, e.cyc);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge.
  task automatic drive(input logic [1:0] op, input logic wie, input logic wepc,
                       input logic [31:0] data, input logic [31:0] pc,
                       input logic [2:0] irq, input logic r);
    @(posedge clk);
    #1;
    op_cp0     = op;
    w_en_ie    = wie;
    w_en_epc   = wepc;
    cp0_w_data = data;
    pc_in      = pc;
    irq_in     = irq;
    rst        = r;
  endtask

  // Queue the outputs expected on this cycle's falling edge.
  task automatic chk(input string name, input logic i, input logic [31:0] vec,
                     input logic [31:0] iev, input logic [31:0] epcv, input logic [2:0] p);
    exp_t e;
    e.cyc = cyc; e.name = name; e.i = i; e.vec = vec;
    e.ie = iev; e.epc = epcv; e.pend = p;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    drive(CP0_OP_NOP, 0, 0, 0, 0, 3'b000, 1);
    drive(CP0_OP_NOP, 0, 0, 0, 0, 3'b000, 0);
    chk("reset", 0, 32'h800, 32'h0, 32'h0, 3'b000);
    // MTC0 paths and ERET with nothing in service
    drive(CP0_OP_NOP, 1, 1, 32'h1, 0, 3'b000, 0);
    chk("mtc0_no_bypass", 0, 32'h800, 32'h0, 32'h0, 3'b000);
    drive(CP0_OP_NOP, 1, 0, 32'hA, 0, 3'b000, 0);
    chk("mtc0_both", 0, 32'h800, 32'h1, 32'h1, 3'b000);
    drive(CP0_OP_RET, 0, 0, 0, 0, 3'b000, 0);
    chk("mtc0_ie_only", 0, 32'h800, 32'hA, 32'h1, 3'b000);
    drive(CP0_OP_NOP, 0, 0, 0, 0, 3'b010, 0);
    chk("eret_idle", 0, 32'h800, 32'hB, 32'h1, 3'b000);
    // line 1 rises, then IRQ entry
    drive(CP0_OP_IRQ, 0, 1, 0, 32'h40, 3'b010, 0);
    chk("line1_pending", 1, 32'h810, 32'hB, 32'h1, 3'b010);
    drive(CP0_OP_NOP, 0, 0, 0, 0, 3'b000, 0);
`ifdef CP0_NESTED_EN
    chk("line1_entry", 0, 32'h800, 32'hB, 32'h40, 3'b000);
    drive(CP0_OP_RET, 0, 0, 0, 0, 3'b110, 0);
    chk("in_service_hold", 0, 32'h800, 32'hB, 32'h40, 3'b000);
`else
    chk("line1_entry", 0, 32'h800, 32'hA, 32'h40, 3'b000);
    drive(CP0_OP_RET, 0, 0, 0, 0, 3'b110, 0);
    chk("in_service_hold", 0, 32'h800, 32'hA, 32'h40, 3'b000);
`endif
    // lines 1 and 2 rise together; line 1 first, then line 2
    drive(CP0_OP_IRQ, 0, 1, 0, 32'h50, 3'b110, 0);
    chk("two_rise_prio", 1, 32'h810, 32'hB, 32'h40, 3'b110);
    drive(CP0_OP_RET, 0, 0, 0, 0, 3'b110, 0);
`ifdef CP0_NESTED_EN
    chk("line1_entry2", 0, 32'h800, 32'hB, 32'h50, 3'b100);
`else
    chk("line1_entry2", 0, 32'h800, 32'hA, 32'h50, 3'b100);
`endif
    drive(CP0_OP_IRQ, 0, 1, 0, 32'h40, 3'b110, 0);
    chk("line2_after_ret", 1, 32'h820, 32'hB, 32'h50, 3'b100);
    // line 0 rises while line 2 is in service
    drive(CP0_OP_NOP, 0, 0, 0, 0, 3'b111, 0);
`ifdef CP0_NESTED_EN
    chk("line2_entry", 0, 32'h800, 32'hB, 32'h40, 3'b000);
    drive(CP0_OP_IRQ, 0, 1, 0, 32'h80, 3'b111, 0);
    chk("nest_preempt", 1, 32'h800, 32'hB, 32'h40, 3'b001);
    drive(CP0_OP_RET, 0, 0, 0, 0, 3'b111, 0);
    chk("nest_full", 0, 32'h800, 32'hB, 32'h80, 3'b000);
    drive(CP0_OP_RET, 0, 0, 0, 0, 3'b110, 0);
    chk("nest_ret1", 0, 32'h800, 32'hB, 32'h40, 3'b000);
    drive(CP0_OP_IRQ, 0, 1, 0, 32'h70, 3'b111, 0);
    chk("nest_ret2", 0, 32'h800, 32'hB, 32'h40, 3'b000);
    drive(CP0_OP_RET, 0, 0, 0, 0, 3'b111, 0);
    chk("nest_stale_irq", 1, 32'h800, 32'hB, 32'h40, 3'b001);
    drive(CP0_OP_NOP, 0, 0, 0, 0, 3'b010, 0);
    chk("nest_ret_empty", 1, 32'h800, 32'hB, 32'h40, 3'b001);
    drive(CP0_OP_IRQ, 0, 1, 0, 32'h90, 3'b111, 0);
    chk("pre_entry0", 1, 32'h800, 32'hB, 32'h40, 3'b001);
    drive(CP0_OP_NOP, 0, 0, 0, 0, 3'b111, 1);
    chk("pre_reset", 0, 32'h800, 32'hB, 32'h90, 3'b101);
`else
    chk("line2_entry", 0, 32'h800, 32'hA, 32'h40, 3'b000);
    drive(CP0_OP_IRQ, 0, 1, 0, 32'h80, 3'b111, 0);
    chk("nest_masked", 0, 32'h800, 32'hA, 32'h40, 3'b001);
    drive(CP0_OP_RET, 0, 0, 0, 0, 3'b111, 0);
    chk("stale_irq_ignored", 0, 32'h800, 32'hA, 32'h40, 3'b001);
    drive(CP0_OP_RET, 0, 0, 0, 0, 3'b110, 0);
    chk("line0_after_ret", 1, 32'h800, 32'hB, 32'h40, 3'b001);
    // entry of line 0 in the same cycle line 0 rises again
    drive(CP0_OP_IRQ, 0, 1, 0, 32'h70, 3'b111, 0);
    chk("ret_idle_again", 1, 32'h800, 32'hB, 32'h40, 3'b001);
    drive(CP0_OP_RET, 0, 0, 0, 0, 3'b111, 0);
    chk("set_wins", 0, 32'h800, 32'hA, 32'h70, 3'b001);
    drive(CP0_OP_NOP, 0, 0, 0, 0, 3'b010, 0);
    chk("set_wins_int", 1, 32'h800, 32'hB, 32'h70, 3'b001);
    drive(CP0_OP_IRQ, 0, 1, 0, 32'h90, 3'b111, 0);
    chk("pre_entry0", 1, 32'h800, 32'hB, 32'h70, 3'b001);
    drive(CP0_OP_NOP, 0, 0, 0, 0, 3'b111, 1);
    chk("pre_reset", 0, 32'h800, 32'hA, 32'h90, 3'b101);
`endif
    // reset in the middle of a handler with lines 0 and 2 pending
    drive(CP0_OP_NOP, 0, 0, 0, 0, 3'b000, 0);
    chk("reset_mid_handler", 0, 32'h800, 32'h0, 32'h0, 3'b000);
    drive(CP0_OP_IRQ, 0, 1, 0, 32'hAA, 3'b000, 0);
    chk("post_reset_idle", 0, 32'h800, 32'h0, 32'h0, 3'b000);
    drive(CP0_OP_NOP, 0, 0, 0, 0, 3'b000, 0);
    chk("stale_after_reset", 0, 32'h800, 32'h0, 32'h0, 3'b000);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_int_unit.md
Name: cp0_int_unit

Overview:
- Coprocessor-0 interrupt responder: the other end of the control unit's interrupt handshake.
- Latches external interrupt lines and raises `int` toward control.
- Executes control's CP0 commands at commit: IRQ entry, ERET, and MTC0 writes to IE/EPC.
- Supplies `ie`, `epc` and the handler vector to control and to the PC/next-PC logic.

Parameters:
- NUM_IRQ, 3, number of external interrupt lines; index 0 is highest priority.
- VEC_BASE, 32'h0000_0800, address of the handler for line 0.
- VEC_STRIDE, 32'h0000_0010, address spacing between handler vectors.
- EPC_DEPTH, 2, EPC stack depth; only used with CP0_NESTED_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- irq_in  in  NUM_IRQ  external interrupt lines, level; already synchronous to clk
- op_cp0  in  CP0_OP_BIT  committed CP0 command: CP0_OP_NOP / CP0_OP_IRQ / CP0_OP_RET
- w_en_ie  in  1  committed IE write enable
- w_en_epc  in  1  committed EPC write enable
- cp0_w_data  in  32  MTC0 write data
- pc_in  in  32  return PC captured on IRQ entry
- int  out  1  an eligible pending interrupt exists
- int_vector  out  32  handler address of the highest-priority eligible line
- ie  out  32  IE register; bit 0 is the global enable
- epc  out  32  current EPC, i.e. the ERET target
- pending  out  NUM_IRQ  latched pending bits, for debug

Behaviour:
- Reset: pending=0, ie=0, epc=0, in-service state=0, irq_prev=0. Outputs int=0, int_vector=VEC_BASE.
- Edge capture: a rising edge on irq_in[i] (irq_prev[i]=0, irq_in[i]=1) sets pending[i] on the next clk. Levels held high do not re-trigger.
- Eligibility: pending[i] is eligible unless it is masked by the in-service state (see Optional Feature).
- int = OR of eligible bits. int is combinational from registers and is NOT gated by ie[0]; control gates it with ie[0].
- sel = lowest eligible index. int_vector = VEC_BASE + sel*VEC_STRIDE, combinational, 32-bit wrap.
- Commit decode, exactly one action per cycle, in priority order:
  - IRQ: op_cp0==CP0_OP_IRQ and w_en_epc and int. Then epc<=pc_in; ie[0]<=0; pending[sel]<=0; sel is marked in service.
  - IRQ with int=0: ignored entirely (stale entry).
  - RET: op_cp0==CP0_OP_RET. Then ie[0]<=1 and in-service state is cleared/popped. With nothing in service, only ie[0]<=1.
  - MTC0: op_cp0==CP0_OP_NOP. w_en_ie writes ie<=cp0_w_data; w_en_epc writes epc<=cp0_w_data; both may be set in one cycle.
- Simultaneous rising edge on line i and IRQ entry clearing pending[i]: the set wins, pending[i] stays 1 as a new event.
- Latency:
  - irq_in rise -> int=1 one cycle later.
  - Commit -> ie/epc/pending update on the next clk edge.
  - Register writes are not bypassed to outputs within the same cycle; control handles that hazard with int_nop.
- Reset asserted mid-handler: all state returns to reset values, and any pending interrupts are lost.

Optional Feature:
- Macro: CP0_NESTED_EN.
- Defined:
  - In-service state is a stack of EPC_DEPTH {epc, level} entries.
  - A line is eligible only if its index is lower than the top-of-stack level; empty stack means all lines eligible.
  - IRQ entry pushes and leaves ie[0] unchanged.
  - RET pops: epc restores the previous entry and ie[0]<=1.
  - Full stack: int is forced to 0.
  - MTC0 to EPC writes the top-of-stack entry.
- Undefined: single EPC register and a 1-bit in_service flag. While in_service=1 no line is eligible. RET clears in_service.

Decomposition:
- Shared core package holds: CP0_OP_BIT, CP0_OP_NOP/IRQ/RET, and CP0 register numbers (IE=rd[1], EPC=rd[0]). These are already used by control and must be reused, not redefined.
- One natural sub-module: cp0_irq_prio_enc (eligible mask -> sel index and valid), parameterised by NUM_IRQ.

Test Plan:
- Reset, then irq_in=3'b010 rise -> pending=010 and int=1 next cycle, int_vector=32'h0810. Commit IRQ with pc_in=32'h0000_0040 -> epc=32'h40, ie[0]=0, pending=000.
- irq_in=3'b110 rising together -> int_vector=32'h0810 (line 1 first). After IRQ entry then RET, line 2 is serviced with vector 32'h0820.
- MTC0 with w_en_ie=1, w_en_epc=1, cp0_w_data=32'h1 -> ie=1, epc=1. ERET with nothing in service -> ie[0]=1, epc unchanged.
- Rising edge on line 0 in the same cycle its IRQ entry commits -> pending[0] remains 1 and int=1 afterwards.
- Undefined CP0_NESTED_EN: line 0 rises while line 2 is in service -> int=0 until RET. Defined: int=1 immediately; two RETs restore epc in LIFO order (0x80, then 0x40).
- Assert rst while in service with pending=101 -> all outputs return to reset values the next cycle.
